// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: AES InvSubBytes stage. Substitutes one 32-bit word per
// clock through four inverse S-box lookups, then presents the 128-bit result
// over a valid/ready handshake.
// Optional build macro: INV_SBOX_PIPE_EN registers the S-box output before the
// state write, which adds one fill cycle to every BUSY phase.
module inv_sub_bytes_seq #(
    parameter int unsigned BYTE   = 8,
    parameter int unsigned DWORD  = 32,
    parameter int unsigned LENGTH = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LENGTH-1:0] in_state,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] out_state,
    output logic              busy
);

    localparam int unsigned NWORDS = LENGTH / DWORD;
    localparam int unsigned NBYTES = DWORD / BYTE;
    localparam int unsigned CNT_W  = $clog2(NWORDS);

    // FIPS-197 inverse S-box, indexed by the input byte
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e                        state_q;
    logic [NWORDS-1:0][DWORD-1:0]  words_q;
    logic [CNT_W-1:0]              cnt_q;
    logic                          in_ready_q;
    logic                          out_valid_q;
    logic                          busy_q;
    logic [DWORD-1:0]              sel_word;
    logic [DWORD-1:0]              sub_word;

`ifdef INV_SBOX_PIPE_EN
    logic [DWORD-1:0]              pipe_q;
    logic                          fill_q;
    logic [CNT_W-1:0]              wr_idx;

    // Writes trail the lookups by one word while the pipeline register is in use
    assign wr_idx = cnt_q - CNT_W'(1);
`endif

    assign sel_word  = words_q[cnt_q];
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = words_q;

    // Four parallel inverse S-box lookups on the selected word, byte i to byte i
    always_comb begin
        sub_word = '0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            sub_word[i*BYTE +: BYTE] = INV_SBOX[sel_word[i*BYTE +: BYTE]];
        end
    end

    // Control FSM, word counter, state register and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            words_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef INV_SBOX_PIPE_EN
            pipe_q      <= '0;
            fill_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        words_q    <= in_state;
                        cnt_q      <= '0;
                        state_q    <= S_BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef INV_SBOX_PIPE_EN
                        fill_q     <= 1'b1;
`endif
                    end
                end
                S_BUSY: begin
`ifdef INV_SBOX_PIPE_EN
                    pipe_q <= sub_word;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (fill_q) begin
                        fill_q <= 1'b0;
                    end else begin
                        words_q[wr_idx] <= pipe_q;
                        if (wr_idx == CNT_W'(NWORDS - 1)) begin
                            state_q     <= S_DONE;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
`else
                    words_q[cnt_q] <= sub_word;
                    cnt_q          <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NWORDS - 1)) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Testbench for inv_sub_bytes_seq: directed vectors, backpressure, mid-run
// reset and a randomized round trip through a GF(2^8)-derived S-box model.
module tb_inv_sub_bytes_seq;

`ifdef INV_SBOX_PIPE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif
    localparam int N_RT = 1000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    always #5 clk = ~clk;

    inv_sub_bytes_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    typedef struct {
        string        name;
        logic [127:0] st;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs [5];
    logic [127:0] exp_q [$];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // Forward S-box from its definition (field inverse + affine map); inverse by table inversion
    task automatic build_tables();
        logic [7:0] xi, s;
        for (int x = 0; x < 256; x++) begin
            xi = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
            s = xi ^ rotl8(xi, 1) ^ rotl8(xi, 2) ^ rotl8(xi, 3) ^ rotl8(xi, 4) ^ 8'h63;
            fwd_tbl[x] = s;
            inv_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] fwd_state(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = fwd_tbl[v[i*8 +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] inv_state(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = inv_tbl[v[i*8 +: 8]];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One state through the block with out_ready high: latency, result, release
    task automatic send_and_check(input string name, input logic [127:0] st, input logic [127:0] exp);
        int lat;
        out_ready = 1'b1;
        check({name, "_in_ready"}, 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_state = st;
        tick();
        in_valid = 1'b0;
        in_state = {4{$urandom}};
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            tick();
            if (out_valid === 1'b1) lat = c;
        end
        check({name, "_latency"}, 128'(lat), 128'(LAT));
        check({name, "_out_state"}, out_state, exp);
        check({name, "_busy_done"}, 128'(busy), 128'(0));
        check({name, "_in_ready_done"}, 128'(in_ready), 128'(0));
        tick();
        check({name, "_out_valid_drop"}, 128'(out_valid), 128'(0));
        check({name, "_in_ready_back"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        int rises;
        int lat;
        logic [127:0] bp_exp;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_state  = '0;
        build_tables();

        vecs[0] = '{"all63", {4{32'h63636363}}, 128'h0};
        vecs[1] = '{"word_order", 128'h63636363_63636363_ED16ED16_007C0063,
                    128'h00000000_00000000_53FF53FF_52015200};
        vecs[2] = '{"all00", 128'h0, {4{32'h52525252}}};
        for (int i = 3; i < 5; i++) begin
            vecs[i].name = (i == 3) ? "rand_a" : "rand_b";
            vecs[i].st   = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].exp  = inv_state(vecs[i].st);
        end

        // Reset values
        repeat (3) tick();
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_state", out_state, 128'h0);
        check("rst_busy", 128'(busy), 128'(0));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) send_and_check(vecs[i].name, vecs[i].st, vecs[i].exp);

        // Backpressure: result holds while out_ready is low; in_valid is ignored meanwhile
        bp_exp    = vecs[1].exp;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = vecs[1].st;
        tick();
        in_state  = 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa;
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            tick();
            if (out_valid === 1'b1) lat = c;
        end
        check("bp_latency", 128'(lat), 128'(LAT));
        for (int c = 0; c < 10; c++) begin
            check("bp_out_valid", 128'(out_valid), 128'(1));
            check("bp_out_state", out_state, bp_exp);
            check("bp_in_ready", 128'(in_ready), 128'(0));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", 128'(out_valid), 128'(0));
        check("bp_release_in_ready", 128'(in_ready), 128'(1));

        // Reset in the middle of BUSY discards the partial result
        in_valid = 1'b1;
        in_state = 128'h0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_out_state", out_state, 128'h0);
        check("midrst_busy", 128'(busy), 128'(0));
        #20;
        rst_n = 1'b1;
        rises = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid === 1'b1) rises++;
        end
        check("midrst_no_out_valid", 128'(rises), 128'(0));
        send_and_check("midrst_resend", 128'h0, {4{32'h52525252}});

        // Randomized round trip: forward S-box model, then the DUT, must give back the original
        fork
            begin : driver
                logic [127:0] p;
                int waited;
                for (int i = 0; i < N_RT; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    p        = {$urandom, $urandom, $urandom, $urandom};
                    in_state = fwd_state(p);
                    in_valid = 1'b1;
                    waited   = 0;
                    while (in_ready !== 1'b1 && waited < 100) begin
                        tick();
                        waited++;
                    end
                    if (waited >= 100) begin
                        check("rt_accept_timeout", 128'(waited), 128'(0));
                        in_valid = 1'b0;
                        break;
                    end
                    exp_q.push_back(p);
                    tick();
                    in_valid = 1'b0;
                end
            end
            begin : monitor
                int rx;
                int cyc;
                rx  = 0;
                cyc = 0;
                while (rx < N_RT && cyc < 40000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid === 1'b1 && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rt_unexpected_output", out_state, 128'h0 ^ ~out_state);
                        end else begin
                            check("rt_roundtrip", out_state, exp_q.pop_front());
                        end
                        rx++;
                    end
                    tick();
                    cyc++;
                end
                check("rt_rx_count", 128'(rx), 128'(N_RT));
            end
        join
        out_ready = 1'b1;
        rises = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid === 1'b1) rises++;
        end
        check("rt_no_extra_output", 128'(rises), 128'(0));
        check("rt_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
